// File: rtl/fnn_pkg.sv
// Shared types and helpers for the feed-forward network datapath.
// Contents:
//   WEIGHT_W       - default weight word width (signed fixed point)
//   wfetch_state_t - weight fetch sequencer state encoding
//   clog2_min1()   - ceil(log2(n)), never less than 1, for index widths
package fnn_pkg;

    localparam int unsigned WEIGHT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } wfetch_state_t;

    // Width of an index able to address n items; a 1-item space still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
        return w;
    endfunction

endpackage

// File: rtl/w_fetch_skid_fifo.sv
// Two-entry skid FIFO between the weight memory read port and the MAC stream.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_push    - write i_din this cycle
//   i_pop     - consume the head entry this cycle (ignored when empty)
//   i_flush   - discard all entries; dominates push and pop
//   i_din     - entry to write ({data, index})
//   o_occ     - number of valid entries (0..2)
//   o_head    - oldest entry; stable until popped
module w_fetch_skid_fifo #(
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_occ != 2'd0);

    // Storage, pointers and occupancy; push and pop may occur together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + 2'(i_push) - 2'(w_do_pop);
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rptr];

    // The upstream credit rule must never let a push land on a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_flush && !w_do_pop && (r_occ == 2'd2)));

endmodule

// File: rtl/w_mem_fetch_seq.sv
// Weight fetch sequencer: walks a 1-cycle-latency weight ROM from index 0 to
// NUM_WEIGHT-1 and streams the words to a MAC over valid/ready, one per cycle
// at full rate, with a 2-entry skid FIFO absorbing the read latency.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - begin one pass (sampled only in IDLE)
//   abort                 - synchronous flush back to IDLE, no done pulse
//   busy                  - high while fetching or draining
//   done                  - one-cycle pulse after the last beat handshake
//   mem_ren, mem_radd     - weight memory read request
//   mem_rdata             - weight memory data, valid the cycle after mem_ren
//   w_valid, w_ready      - stream handshake
//   w_data, w_idx, w_last - stream payload; w_last marks index NUM_WEIGHT-1
module w_mem_fetch_seq
    import fnn_pkg::*;
#(
    parameter int unsigned NUM_WEIGHT = 30,
    parameter int unsigned ADDR_W     = clog2_min1(NUM_WEIGHT),
    parameter int unsigned DATA_W     = WEIGHT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_radd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_idx,
    output logic              w_last
);

    localparam int unsigned       ENTRY_W  = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);

    wfetch_state_t      r_state;
    wfetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0]  r_issue_cnt;
    logic [ADDR_W-1:0]  r_infl_idx;
    logic               r_inflight;
    logic               r_done;

    logic               w_issue;
    logic               w_done_nxt;
    logic               w_pop;
    logic               w_flush;
    logic               w_credit_ok;
    logic               w_head_last;
    logic               w_fifo_valid;
    logic [1:0]         w_occ;
    logic [ENTRY_W-1:0] w_head;
    logic [DATA_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_head_idx;

    assign {w_head_data, w_head_idx} = w_head;

    assign w_fifo_valid = (w_occ != 2'd0);
    assign w_pop        = w_fifo_valid && w_ready;
    assign w_head_last  = (w_head_idx == LAST_IDX);
    assign w_flush      = abort && (r_state != IDLE);

    // A new read may issue only if it still has a FIFO slot once this cycle's
    // pop leaves; counting the pop keeps full rate under continuous ready.
    assign w_credit_ok = (3'(w_occ) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, read issue and done decode; abort outranks start and handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_issue = w_credit_ok;
                    if (w_issue && (r_issue_cnt == LAST_IDX)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_pop && w_head_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Issue counter: holds on the final address so it never passes NUM_WEIGHT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_issue_cnt <= '0;
        end else if (w_issue && (r_issue_cnt != LAST_IDX)) begin
            r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
        end
    end

    // Tracks the read in flight so its data is captured with its index next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_infl_idx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_infl_idx <= r_issue_cnt;
            r_done     <= w_done_nxt;
        end
    end

    w_fetch_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   ({mem_rdata, r_infl_idx}),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign mem_ren  = w_issue;
    assign mem_radd = r_issue_cnt;
    assign w_valid  = w_fifo_valid;
    assign w_data   = w_head_data;
    assign w_idx    = w_head_idx;
    assign w_last   = w_fifo_valid && w_head_last;

endmodule

// File: tb/tb_w_mem_fetch_seq.sv
// Directed bench for w_mem_fetch_seq: a 30-weight instance plus a 1-weight
// instance, each fed by a 1-cycle registered ROM holding 16'h1000 + index.
module tb_w_mem_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, w_ready;
    logic        busy, done, mem_ren, w_valid, w_last;
    logic [4:0]  mem_radd, w_idx;
    logic [15:0] mem_rdata, w_data;

    logic        start_b, abort_b, w_ready_b;
    logic        busy_b, done_b, mem_ren_b, w_valid_b, w_last_b;
    logic [0:0]  mem_radd_b, w_idx_b;
    logic [15:0] mem_rdata_b, w_data_b;

    w_mem_fetch_seq #(.NUM_WEIGHT(30), .ADDR_W(5), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx), .w_last(w_last)
    );

    w_mem_fetch_seq #(.NUM_WEIGHT(1), .ADDR_W(1), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
        .mem_ren(mem_ren_b), .mem_radd(mem_radd_b), .mem_rdata(mem_rdata_b),
        .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b), .w_idx(w_idx_b), .w_last(w_last_b)
    );

    // Registered-read weight ROMs.
    always @(posedge clk) if (mem_ren)   mem_rdata   <= 16'h1000 + 16'(mem_radd);
    always @(posedge clk) if (mem_ren_b) mem_rdata_b <= 16'h1000 + 16'(mem_radd_b);

    int n_assert = 0;
    int n_fail   = 0;
    int outst    = 0;
    logic ren_s, pop_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; track reads issued minus beats taken (occ + inflight).
    task automatic step();
        ren_s = mem_ren;
        pop_s = w_valid && w_ready;
        @(posedge clk);
        #1;
        outst = outst + int'(ren_s) - int'(pop_s);
    endtask

    initial begin
        int          exp_idx, ei, stall_left, beats;
        logic        ev, stalled_done, start7_done, got_done, found;
        logic        prev_valid, prev_ready;
        logic [4:0]  prev_idx;
        logic [15:0] prev_data;

        rst = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; w_ready_b = 1'b1;

        // 1. Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_mem_ren",  32'(mem_ren),  32'd0);
        chk("rst_mem_radd", 32'(mem_radd), 32'd0);
        chk("rst_w_valid",  32'(w_valid),  32'd0);
        chk("rst_w_last",   32'(w_last),   32'd0);
        chk("rst_w_data",   32'(w_data),   32'd0);
        chk("rst_w_idx",    32'(w_idx),    32'd0);
        chk("rst_b_valid",  32'(w_valid_b), 32'd0);
        chk("rst_b_last",   32'(w_last_b),  32'd0);
        chk("rst_b_busy",   32'(busy_b),    32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_busy",    32'(busy),    32'd0);
            chk("idle_mem_ren", 32'(mem_ren), 32'd0);
            chk("idle_w_valid", 32'(w_valid), 32'd0);
            chk("idle_done",    32'(done),    32'd0);
            step();
        end
        outst = 0;

        // 2. Full rate pass; a start in the done cycle launches the next pass.
        w_ready = 1'b1;
        start = 1'b1;
        #1;
        chk("t2_busy_N",    32'(busy),    32'd0);
        chk("t2_mem_ren_N", 32'(mem_ren), 32'd0);
        step();
        for (int k = 1; k <= 36; k++) begin
            start = (k == 33);
            #1;
            ev = ((k >= 3) && (k <= 32)) || (k == 36);
            ei = (k <= 32) ? (k - 3) : 0;
            chk("t2_valid", 32'(w_valid), 32'(ev));
            if (ev) begin
                chk("t2_idx",  32'(w_idx),  32'(ei));
                chk("t2_data", 32'(w_data), 32'h1000 + 32'(ei));
                chk("t2_last", 32'(w_last), 32'(ei == 29));
            end else begin
                chk("t2_last_low", 32'(w_last), 32'd0);
            end
            chk("t2_done", 32'(done), 32'(k == 33));
            chk("t2_busy", 32'(busy), 32'(k != 33));
            if (k == 1) begin
                chk("t2_mem_ren_N1",  32'(mem_ren),  32'd1);
                chk("t2_mem_radd_N1", 32'(mem_radd), 32'd0);
            end
            step();
        end

        // 3/4. Backpressure stall at idx 10 then random ready; start while busy at idx 7.
        exp_idx = 1; stall_left = 0;
        stalled_done = 1'b0; start7_done = 1'b0; got_done = 1'b0;
        prev_valid = 1'b1; prev_ready = 1'b1; prev_idx = '0; prev_data = '0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            start = 1'b0;
            if (!stalled_done && w_valid && (w_idx == 5'd10)) begin
                stall_left = 5;
                stalled_done = 1'b1;
            end
            if (stall_left > 0) begin
                w_ready = 1'b0;
                stall_left--;
            end else if (stalled_done) begin
                w_ready = 1'($urandom_range(0, 1));
            end else begin
                w_ready = 1'b1;
            end
            if (!start7_done && w_valid && (w_idx == 5'd7)) begin
                start = 1'b1;
                start7_done = 1'b1;
            end
            #1;
            if (prev_valid && !prev_ready) begin
                chk("t3_hold_idx",  32'(w_idx),  32'(prev_idx));
                chk("t3_hold_data", 32'(w_data), 32'(prev_data));
            end
            if (w_valid) begin
                chk("t3_idx",  32'(w_idx),  32'(exp_idx));
                chk("t3_data", 32'(w_data), 32'h1000 + 32'(exp_idx));
                chk("t3_last", 32'(w_last), 32'(exp_idx == 29));
            end
            chk("t3_outstanding_le2", 32'(outst <= 2), 32'd1);
            if (done) begin
                got_done = 1'b1;
                chk("t3_beats_at_done", 32'(exp_idx), 32'd30);
                chk("t3_busy_at_done",  32'(busy),    32'd0);
            end else begin
                chk("t3_busy", 32'(busy), 32'd1);
            end
            prev_valid = w_valid; prev_ready = w_ready;
            prev_idx = w_idx; prev_data = w_data;
            if (w_valid && w_ready) exp_idx++;
            step();
        end
        chk("t3_done_seen", 32'(got_done), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_done_once", 32'(done), 32'd0);
            chk("t3_idle_busy", 32'(busy), 32'd0);
            step();
        end

        // 5. Abort at the handshake of idx 12, then restart from idx 0.
        w_ready = 1'b1;
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (w_valid && (w_idx == 5'd12)) begin
                found = 1'b1;
                abort = 1'b1;
            end
            #1;
            step();
        end
        abort = 1'b0;
        #1;
        chk("t5_found_idx12", 32'(found),   32'd1);
        chk("t5_valid",       32'(w_valid), 32'd0);
        chk("t5_busy",        32'(busy),    32'd0);
        chk("t5_mem_ren",     32'(mem_ren), 32'd0);
        chk("t5_done",        32'(done),    32'd0);
        outst = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("t5_no_done",  32'(done),    32'd0);
            chk("t5_no_valid", 32'(w_valid), 32'd0);
        end
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        #1;
        step();
        #1;
        step();
        #1;
        chk("t5_restart_valid", 32'(w_valid), 32'd1);
        chk("t5_restart_idx",   32'(w_idx),   32'd0);
        chk("t5_restart_data",  32'(w_data),  32'h1000);

        // 6. Asynchronous reset while draining, then a clean pass.
        step();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (w_valid && (w_idx == 5'd28)) begin
                found = 1'b1;
            end else begin
                #1;
                step();
            end
        end
        chk("t6_found_idx28", 32'(found), 32'd1);
        #1;
        chk("t6_in_drain_busy", 32'(busy),    32'd1);
        chk("t6_in_drain_ren",  32'(mem_ren), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(busy),     32'd0);
        chk("t6_rst_valid", 32'(w_valid),  32'd0);
        chk("t6_rst_ren",   32'(mem_ren),  32'd0);
        chk("t6_rst_radd",  32'(mem_radd), 32'd0);
        chk("t6_rst_idx",   32'(w_idx),    32'd0);
        chk("t6_rst_data",  32'(w_data),   32'd0);
        chk("t6_rst_last",  32'(w_last),   32'd0);
        chk("t6_rst_done",  32'(done),     32'd0);
        step(); step();
        rst = 1'b0;
        outst = 0;
        start = 1'b1;
        #1;
        step();
        start = 1'b0;
        beats = 0;
        for (int k = 1; k <= 34; k++) begin
            #1;
            ev = (k >= 3) && (k <= 32);
            chk("t6_valid", 32'(w_valid), 32'(ev));
            if (w_valid) begin
                chk("t6_idx",  32'(w_idx),  32'(beats));
                chk("t6_data", 32'(w_data), 32'h1000 + 32'(beats));
                chk("t6_last", 32'(w_last), 32'(beats == 29));
                beats++;
            end
            chk("t6_done", 32'(done), 32'(k == 33));
            step();
        end
        chk("t6_beats", 32'(beats), 32'd30);

        // NUM_WEIGHT = 1: a single beat flagged last, done at N+4.
        start_b = 1'b1;
        #1;
        step();
        start_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("nw1_valid", 32'(w_valid_b), 32'(k == 3));
            chk("nw1_last",  32'(w_last_b),  32'(k == 3));
            chk("nw1_done",  32'(done_b),    32'(k == 4));
            chk("nw1_busy",  32'(busy_b),    32'(k <= 3));
            if (k == 3) begin
                chk("nw1_data", 32'(w_data_b), 32'h1000);
                chk("nw1_idx",  32'(w_idx_b),  32'd0);
            end
            if (k <= 2) begin
                chk("nw1_mem_ren", 32'(mem_ren_b), 32'(k == 1));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
